// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one imem read outstanding and buffers {pc, instr} pairs for decode.
// Latency: request in cycle N gives instr_valid in N+1 with zero-wait memory; 1 instr/cycle sustained.
// Backpressure: stall holds the FIFO head; a read is only issued when a FIFO slot is guaranteed for it.

module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop_rdy,
    output logic                   head_vld,
    output logic [WIDTH-1:0]       head_dat,
    output logic [$clog2(DEPTH):0] cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop_rdy && (cnt_q != '0) && !flush;
        do_push  = push_vld && !flush && ((cnt_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push) mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign head_vld = (cnt_q != '0);
    assign head_dat = mem_q[rd_ptr_q];
    assign cnt      = cnt_q;
endmodule

module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] i_address,
    output logic        i_read,
    input  logic        i_ack,
    input  logic [31:0] i_data_in,
    input  logic        load_new_PC,
    input  logic [31:0] new_PC,
    input  logic        stall,
    output logic [31:0] instr_out,
    output logic [31:0] pc_val,
    output logic        instr_valid
);
    localparam int          CW       = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W  = (CW+1)'(BUF_DEPTH);
    localparam logic [31:0] START_PC = RESET_PC & ~32'h3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_ent_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] pend_q, pend_d;
    logic        rd_q, rd_d;

    fetch_ent_t  push_ent, head_ent;
    logic        push_vld, pop_rdy, head_vld;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0] occ_after_pop;
    logic        slot_free, slot_after_push;
    logic [31:0] redir_tgt;
    logic        ack_vld;

    always_comb begin
        ack_vld         = i_ack && rd_q;
        pop_rdy         = head_vld && !stall;
        occ_after_pop   = {1'b0, fifo_cnt} - (CW+1)'(pop_rdy);
        slot_free       = occ_after_pop < DEPTH_W;
        slot_after_push = (occ_after_pop + (CW+1)'(1)) < DEPTH_W;
        push_vld        = (state_q == FETCH) && ack_vld && !load_new_PC;
        push_ent        = '{pc: addr_q, instr: i_data_in};
        redir_tgt       = new_PC & ~32'h3;
    end

    fetch_fifo #(
        .WIDTH($bits(fetch_ent_t)),
        .DEPTH(BUF_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (load_new_PC),
        .push_vld (push_vld),
        .push_dat (push_ent),
        .pop_rdy  (pop_rdy),
        .head_vld (head_vld),
        .head_dat (head_ent),
        .cnt      (fifo_cnt)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        if (load_new_PC) begin
            // The flush makes a slot available, so a redirect can always fetch at once.
            case (state_q)
                IDLE: begin
                    addr_d  = redir_tgt;
                    state_d = FETCH;
                end
                FETCH: begin
                    if (ack_vld) begin
                        addr_d  = redir_tgt;
                        state_d = FETCH;
                    end else begin
                        pend_d  = redir_tgt;
                        state_d = DISCARD;
                    end
                end
                DISCARD: begin
                    pend_d = redir_tgt;
                    if (ack_vld) begin
                        addr_d  = redir_tgt;
                        state_d = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (slot_free) state_d = FETCH;
                end
                FETCH: begin
                    if (ack_vld) begin
                        addr_d  = addr_q + 32'd4;
                        state_d = slot_after_push ? FETCH : IDLE;
                    end
                end
                DISCARD: begin
                    if (ack_vld) begin
                        addr_d  = pend_q;
                        state_d = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        rd_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= START_PC;
            pend_q  <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            rd_q    <= rd_d;
        end
    end

    assign i_address   = addr_q;
    assign i_read      = rd_q;
    assign instr_valid = head_vld;
    assign instr_out   = head_vld ? head_ent.instr : '0;
    assign pc_val      = head_vld ? head_ent.pc : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table, hand sequences for wait states and async reset,
// then a randomized run checked against an in-order stream model of the fetched instructions.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_ack = 1'b0;
    logic        load_new_PC = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] i_data_in = '0;
    logic [31:0] new_PC = '0;
    logic        i_read, instr_valid;
    logic [31:0] i_address, instr_out, pc_val;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_address   (i_address),
        .i_read      (i_read),
        .i_ack       (i_ack),
        .i_data_in   (i_data_in),
        .load_new_PC (load_new_PC),
        .new_PC      (new_PC),
        .stall       (stall),
        .instr_out   (instr_out),
        .pc_val      (pc_val),
        .instr_valid (instr_valid)
    );

    typedef struct {
        logic        rst_n;
        logic        ack;
        logic        ld;
        logic [31:0] npc;
        logic        stl;
        logic        e_rd;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
    } vec_t;

    // Instruction memory contents as a function of the word address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_9617;
    endfunction

    function automatic vec_t mk(input logic rst_n, input logic ack, input logic ld,
                                input logic [31:0] npc, input logic stl, input logic e_rd,
                                input logic [31:0] e_addr, input logic e_vld, input logic [31:0] e_pc);
        vec_t v;
        v.rst_n = rst_n; v.ack = ack; v.ld = ld; v.npc = npc; v.stl = stl;
        v.e_rd = e_rd; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_rd, input logic [31:0] e_addr,
                              input logic e_vld, input logic [31:0] e_pc);
        check({tag, ".i_read"}, 32'(i_read), 32'(e_rd));
        check({tag, ".i_address"}, i_address, e_addr);
        check({tag, ".instr_valid"}, 32'(instr_valid), 32'(e_vld));
        check({tag, ".pc_val"}, pc_val, e_vld ? e_pc : 32'h0);
        check({tag, ".instr_out"}, instr_out, e_vld ? memf(e_pc) : 32'h0);
    endtask

    initial begin
        vec_t        tv[$];
        logic [31:0] exp_pc, prev_addr;
        logic        redir_prev, prev_rd, prev_ack;
        int          consumed;

        //           rst ack ld  new_PC        stl  rd  addr          vld pc
        tv.push_back(mk(1, 1, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0));
        tv.push_back(mk(1, 1, 0, 32'h0,         0,  1, 32'h0,         0, 32'h0));
        tv.push_back(mk(1, 1, 0, 32'h0,         0,  1, 32'h4,         1, 32'h0));
        tv.push_back(mk(1, 1, 0, 32'h0,         0,  1, 32'h8,         1, 32'h4));
        tv.push_back(mk(1, 1, 0, 32'h0,         1,  1, 32'hC,         1, 32'h8));
        tv.push_back(mk(1, 1, 0, 32'h0,         1,  0, 32'h10,        1, 32'h8));
        tv.push_back(mk(1, 1, 0, 32'h0,         0,  0, 32'h10,        1, 32'h8));
        tv.push_back(mk(1, 1, 0, 32'h0,         0,  1, 32'h10,        1, 32'hC));
        tv.push_back(mk(1, 1, 0, 32'h0,         0,  1, 32'h14,        1, 32'h10));
        tv.push_back(mk(1, 1, 1, 32'h203,       0,  1, 32'h18,        1, 32'h14));
        tv.push_back(mk(1, 0, 0, 32'h0,         0,  1, 32'h200,       0, 32'h0));
        tv.push_back(mk(1, 1, 0, 32'h0,         0,  1, 32'h200,       0, 32'h0));
        tv.push_back(mk(1, 1, 0, 32'h0,         0,  1, 32'h204,       1, 32'h200));
        tv.push_back(mk(1, 0, 1, 32'h100,       0,  1, 32'h208,       1, 32'h204));
        tv.push_back(mk(1, 0, 0, 32'h0,         0,  1, 32'h208,       0, 32'h0));
        tv.push_back(mk(1, 0, 1, 32'h300,       0,  1, 32'h208,       0, 32'h0));
        tv.push_back(mk(1, 0, 1, 32'h404,       0,  1, 32'h208,       0, 32'h0));
        tv.push_back(mk(1, 1, 0, 32'h0,         0,  1, 32'h208,       0, 32'h0));
        tv.push_back(mk(1, 1, 0, 32'h0,         0,  1, 32'h404,       0, 32'h0));
        tv.push_back(mk(1, 0, 0, 32'h0,         0,  1, 32'h408,       1, 32'h404));
        tv.push_back(mk(1, 0, 1, 32'h500,       0,  1, 32'h408,       0, 32'h0));
        tv.push_back(mk(1, 1, 1, 32'h5FF,       0,  1, 32'h408,       0, 32'h0));
        tv.push_back(mk(1, 1, 0, 32'h0,         0,  1, 32'h5FC,       0, 32'h0));
        tv.push_back(mk(1, 1, 1, 32'hFFFF_FFFE, 0,  1, 32'h600,       1, 32'h5FC));
        tv.push_back(mk(1, 1, 0, 32'h0,         0,  1, 32'hFFFF_FFFC, 0, 32'h0));
        tv.push_back(mk(1, 1, 0, 32'h0,         0,  1, 32'h0,         1, 32'hFFFF_FFFC));
        tv.push_back(mk(1, 1, 0, 32'h0,         0,  1, 32'h4,         1, 32'h0));

        repeat (3) @(negedge clk);
        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), tv[i].e_rd, tv[i].e_addr, tv[i].e_vld, tv[i].e_pc);
            reset_n     = tv[i].rst_n;
            i_ack       = tv[i].ack;
            load_new_PC = tv[i].ld;
            new_PC      = tv[i].npc;
            stall       = tv[i].stl;
            i_data_in   = memf(i_address);
        end

        // Three wait states: request held stable for four cycles, one push on the ack.
        reset_n = 1'b0; i_ack = 1'b0; load_new_PC = 1'b0; stall = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("wait%0d.i_read", k), 32'(i_read), 32'h1);
            check($sformatf("wait%0d.i_address", k), i_address, 32'h0);
            i_ack     = (k == 3);
            i_data_in = (k == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
        end
        @(negedge clk);
        check("wait.instr_valid", 32'(instr_valid), 32'h1);
        check("wait.instr_out", instr_out, 32'hDEAD_BEEF);
        check("wait.pc_val", pc_val, 32'h0);
        check("wait.next_addr", i_address, 32'h4);
        i_ack = 1'b0;
        @(negedge clk);
        check("wait.single_push", 32'(instr_valid), 32'h0);
        check("wait.addr_hold", i_address, 32'h4);
        i_ack = 1'b1; i_data_in = memf(32'h4); stall = 1'b1;
        @(negedge clk);
        check("pre_rst.pc_val", pc_val, 32'h4);
        check("pre_rst.i_address", i_address, 32'h8);
        i_ack = 1'b0;

        // Asynchronous reset in the middle of a request.
        #2 reset_n = 1'b0;
        #1 check_outs("async_rst", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1; stall = 1'b0; i_ack = 1'b1;
        @(negedge clk);
        check("restart.i_read", 32'(i_read), 32'h1);
        check("restart.i_address", i_address, 32'h0);
        i_data_in = memf(i_address);
        @(negedge clk);
        check_outs("restart", 1'b1, 32'h4, 1'b1, 32'h0);

        // Randomized run: the decode-side stream must be the in-order program from the last redirect.
        reset_n = 1'b0; i_ack = 1'b0; stall = 1'b0; load_new_PC = 1'b0;
        repeat (2) @(negedge clk);
        reset_n    = 1'b1;
        exp_pc     = 32'h0;
        redir_prev = 1'b0;
        prev_rd    = 1'b0;
        prev_ack   = 1'b0;
        prev_addr  = 32'h0;
        consumed   = 0;
        repeat (3000) begin
            @(negedge clk);
            if (redir_prev) check("rnd.flush_vld", 32'(instr_valid), 32'h0);
            if (instr_valid) begin
                check("rnd.pc_val", pc_val, exp_pc);
                check("rnd.instr_out", instr_out, memf(exp_pc));
            end else begin
                check("rnd.empty_outs", pc_val | instr_out, 32'h0);
            end
            if (prev_rd && !prev_ack) begin
                check("rnd.addr_hold", i_address, prev_addr);
                check("rnd.rd_hold", 32'(i_read), 32'h1);
            end
            check("rnd.align", 32'(i_address[1:0]), 32'h0);

            stall       = ($urandom_range(0, 3) == 0);
            load_new_PC = ($urandom_range(0, 19) == 0);
            new_PC      = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : 32'($urandom_range(0, 4095));
            i_ack       = i_read ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
            i_data_in   = i_read ? memf(i_address) : $urandom;

            if (load_new_PC) begin
                exp_pc = new_PC & ~32'h3;
            end else if (instr_valid && !stall) begin
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            redir_prev = load_new_PC;
            prev_rd    = i_read;
            prev_ack   = i_ack;
            prev_addr  = i_address;
        end
        check("rnd.progress", 32'(consumed > 300), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
